// File: rtl/grid_placer.sv
// grid_placer: random-walk placement of dataflow-graph nodes onto a GRID_W x GRID_H
// cell grid, followed by a second pass over the edge list that sums the wiring cost.
// The edge list lives in an external synchronous ROM (data valid the cycle after edge_rd).
module grid_placer #(
    parameter int GRID_W     = 8,
    parameter int GRID_H     = 8,
    parameter int N_NODES    = 64,
    parameter int EDGE_AW    = 9,
    parameter int MAX_TRIES  = 63,
    parameter int MAX_RADIUS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [31:0]                seed,
    input  logic [EDGE_AW-1:0]         n_edge,
    output logic                       edge_rd,
    output logic [EDGE_AW-1:0]         edge_addr,
    input  logic [$clog2(N_NODES)-1:0] edge_src,
    input  logic [$clog2(N_NODES)-1:0] edge_dst,
    output logic                       busy,
    output logic                       done,
    output logic                       fail,
    output logic signed [31:0]         cost,
    output logic signed [31:0]         cost_1hop,
    output logic [31:0]                cycles
);
    localparam int NW    = $clog2(N_NODES);
    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);
    localparam int NCELL = GRID_W * GRID_H;
    localparam int CW    = $clog2(NCELL);
    localparam int TW    = $clog2(MAX_TRIES + 1);
    localparam logic [31:0] TAPS = 32'h8020_0003;

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_WAIT_E, S_PLACE_SRC, S_PLACE_DST,
        S_EVAL_FETCH, S_EVAL_WAIT, S_EVAL_ACC, S_DONE, S_FAIL
    } state_t;

    state_t state, state_n;

    logic [31:0]                lfsr, r;
    logic [EDGE_AW-1:0]         n_edge_r, i;
    logic [NW-1:0]              src_r, dst_r, cur, anc;
    logic [TW-1:0]              t;
    logic [N_NODES-1:0][XW-1:0] pos_x;
    logic [N_NODES-1:0][YW-1:0] pos_y;
    logic [N_NODES-1:0]         placed;
    logic [NCELL-1:0]           occ;
    logic [CW-1:0]              cell_idx;

    logic placing, cur_placed, in_range, ok, advance, give_up, last;
    int   rad, off_x, off_y, cand_x, cand_y, adx, ady;

    // Candidate generation for the node being placed this cycle, plus eval distances.
    always_comb begin
        placing    = (state == S_PLACE_SRC) || (state == S_PLACE_DST);
        cur        = (state == S_PLACE_SRC) ? src_r : dst_r;
        anc        = (state == S_PLACE_SRC) ? dst_r : src_r;
        cur_placed = placed[cur];
        // One Galois step; the attempt uses the post-advance value.
        r          = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : 32'h0);
        // Walk radius widens every 8 rejections, capped.
        rad = 1 + int'(t) / 8;
        if (rad > MAX_RADIUS) rad = MAX_RADIUS;
        off_x = int'(r[7:0])  % (2 * rad + 1) - rad;
        off_y = int'(r[15:8]) % (2 * rad + 1) - rad;
        // Walk around the already-placed partner, else drop anywhere on the grid.
        if (placed[anc]) begin
            cand_x = int'(pos_x[anc]) + off_x;
            cand_y = int'(pos_y[anc]) + off_y;
        end else begin
            cand_x = int'(r[15:0])  % GRID_W;
            cand_y = int'(r[31:16]) % GRID_H;
        end
        in_range = (cand_x >= 0) && (cand_x < GRID_W) && (cand_y >= 0) && (cand_y < GRID_H);
        cell_idx = CW'(cand_y * GRID_W + cand_x);
        ok       = in_range && !occ[cell_idx];
        advance  = placing && (cur_placed || ok);
        give_up  = (int'(t) + 1) >= MAX_TRIES;
        last     = (i == n_edge_r - EDGE_AW'(1));
        adx = int'(pos_x[src_r]) - int'(pos_x[dst_r]);
        if (adx < 0) adx = -adx;
        ady = int'(pos_y[src_r]) - int'(pos_y[dst_r]);
        if (ady < 0) ady = -ady;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state and handshake/ROM outputs.
    always_comb begin
        state_n   = state;
        edge_rd   = 1'b0;
        edge_addr = i;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        case (state)
            S_IDLE:       if (start) state_n = S_CLEAR;
            S_CLEAR:      state_n = (n_edge_r == '0) ? S_DONE : S_FETCH;
            S_FETCH:      begin edge_rd = 1'b1; state_n = S_WAIT_E; end
            S_WAIT_E:     state_n = S_PLACE_SRC;
            S_PLACE_SRC: begin
                if (advance)      state_n = S_PLACE_DST;
                else if (give_up) state_n = S_FAIL;
            end
            S_PLACE_DST: begin
                if (advance)      state_n = last ? S_EVAL_FETCH : S_FETCH;
                else if (give_up) state_n = S_FAIL;
            end
            S_EVAL_FETCH: begin edge_rd = 1'b1; state_n = S_EVAL_WAIT; end
            S_EVAL_WAIT:  state_n = S_EVAL_ACC;
            S_EVAL_ACC:   state_n = last ? S_DONE : S_EVAL_FETCH;
            S_DONE:       begin done = 1'b1; state_n = S_IDLE; end
            S_FAIL:       begin done = 1'b1; state_n = S_IDLE; end
            default:      state_n = S_IDLE;
        endcase
    end

    // Datapath: run setup, placement bookkeeping, cost accumulation, cycle count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr      <= '0;
            n_edge_r  <= '0;
            i         <= '0;
            src_r     <= '0;
            dst_r     <= '0;
            t         <= '0;
            pos_x     <= '0;
            pos_y     <= '0;
            placed    <= '0;
            occ       <= '0;
            fail      <= 1'b0;
            cost      <= '0;
            cost_1hop <= '0;
            cycles    <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                lfsr      <= (seed == 32'd0) ? 32'd1 : seed;
                n_edge_r  <= n_edge;
                i         <= '0;
                fail      <= 1'b0;
                cost      <= '0;
                cost_1hop <= '0;
                // Accept cycle and the final done cycle are counted up front.
                cycles    <= 32'd2;
            end
            if (state == S_CLEAR) begin
                placed <= '0;
                occ    <= '0;
            end
            if (state == S_WAIT_E || state == S_EVAL_WAIT) begin
                src_r <= edge_src;
                dst_r <= edge_dst;
                t     <= '0;
            end
            if (placing && !cur_placed) begin
                lfsr <= r;
                if (ok) begin
                    pos_x[cur]    <= XW'(cand_x);
                    pos_y[cur]    <= YW'(cand_y);
                    placed[cur]   <= 1'b1;
                    occ[cell_idx] <= 1'b1;
                    t             <= '0;
                end else begin
                    t <= t + 1'b1;
                end
            end
            if (state == S_PLACE_DST && advance) i <= last ? '0 : i + 1'b1;
            if (state == S_EVAL_ACC) begin
                cost      <= cost + (adx + ady - 1);
                cost_1hop <= cost_1hop + ((adx + 1) / 2 + (ady + 1) / 2 - 1);
                i         <= i + 1'b1;
            end
            if (state_n == S_FAIL) fail <= 1'b1;
            if (busy && state != S_DONE && state != S_FAIL) cycles <= cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_grid_placer.sv
// Bench for grid_placer: an 8x8 instance for the main runs and a 2x2 instance for
// the exhaustion case, both against a procedural placement/cost reference.
`timescale 1ns/1ps
module tb_grid_placer;
    localparam int MAXT = 63;
    localparam int MAXR = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              a_start, a_rd, a_busy, a_done, a_fail;
    logic [31:0]       a_seed, a_cyc;
    logic [8:0]        a_n, a_addr;
    logic [5:0]        a_src, a_dst;
    logic signed [31:0] a_cost, a_c1;

    logic              b_start, b_rd, b_busy, b_done, b_fail;
    logic [31:0]       b_seed, b_cyc;
    logic [8:0]        b_n, b_addr;
    logic [5:0]        b_src, b_dst;
    logic signed [31:0] b_cost, b_c1;

    logic [5:0] rom_src [512];
    logic [5:0] rom_dst [512];

    int vectors = 0;
    int miscompares = 0;

    int   m_cyc, m_cost, m_c1;
    logic m_fail;

    grid_placer #(.GRID_W(8), .GRID_H(8), .N_NODES(64), .EDGE_AW(9), .MAX_TRIES(MAXT), .MAX_RADIUS(MAXR)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .seed(a_seed), .n_edge(a_n),
        .edge_rd(a_rd), .edge_addr(a_addr), .edge_src(a_src), .edge_dst(a_dst),
        .busy(a_busy), .done(a_done), .fail(a_fail), .cost(a_cost), .cost_1hop(a_c1), .cycles(a_cyc));

    grid_placer #(.GRID_W(2), .GRID_H(2), .N_NODES(64), .EDGE_AW(9), .MAX_TRIES(MAXT), .MAX_RADIUS(MAXR)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .seed(b_seed), .n_edge(b_n),
        .edge_rd(b_rd), .edge_addr(b_addr), .edge_src(b_src), .edge_dst(b_dst),
        .busy(b_busy), .done(b_done), .fail(b_fail), .cost(b_cost), .cost_1hop(b_c1), .cycles(b_cyc));

    // Synchronous edge ROMs: data valid the cycle after the read strobe.
    always_ff @(posedge clk) begin
        if (a_rd) begin a_src <= rom_src[a_addr]; a_dst <= rom_dst[a_addr]; end
        if (b_rd) begin b_src <= rom_src[b_addr]; b_dst <= rom_dst[b_addr]; end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Reference: place every edge's endpoints, then sum costs; also predicts run length.
    task automatic model(input int gw, input int gh, input logic [31:0] sd, input int n);
        logic [31:0] l;
        int px [64];
        int py [64];
        bit pl [64];
        bit oc [64][64];
        l = (sd == 32'd0) ? 32'd1 : sd;
        m_cyc = 2; m_fail = 1'b0; m_cost = 0; m_c1 = 0;
        for (int q = 0; q < 64; q++) begin
            pl[q] = 1'b0; px[q] = 0; py[q] = 0;
            for (int w = 0; w < 64; w++) oc[q][w] = 1'b0;
        end
        for (int e = 0; e < n && !m_fail; e++) begin
            m_cyc += 2;
            for (int s = 0; s < 2 && !m_fail; s++) begin
                int nd, an, t, x, y, rr;
                bit ok;
                nd = (s == 0) ? int'(rom_src[e]) : int'(rom_dst[e]);
                an = (s == 0) ? int'(rom_dst[e]) : int'(rom_src[e]);
                if (pl[nd]) m_cyc += 1;
                else begin
                    ok = 1'b0; t = 0;
                    while (!ok && !m_fail) begin
                        m_cyc += 1;
                        l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
                        rr = (t / 8 + 1 < MAXR) ? t / 8 + 1 : MAXR;
                        if (pl[an]) begin
                            x = px[an] + int'(l[7:0]) % (2 * rr + 1) - rr;
                            y = py[an] + int'(l[15:8]) % (2 * rr + 1) - rr;
                        end else begin
                            x = int'(l[15:0]) % gw;
                            y = int'(l[31:16]) % gh;
                        end
                        if (x >= 0 && x < gw && y >= 0 && y < gh && !oc[x][y]) begin
                            ok = 1'b1; pl[nd] = 1'b1; px[nd] = x; py[nd] = y; oc[x][y] = 1'b1;
                        end else begin
                            t++;
                            if (t == MAXT) m_fail = 1'b1;
                        end
                    end
                end
            end
        end
        if (m_fail) m_cyc += 1;
        else begin
            for (int e = 0; e < n; e++) begin
                int dx, dy;
                dx = px[int'(rom_src[e])] - px[int'(rom_dst[e])];
                dy = py[int'(rom_src[e])] - py[int'(rom_dst[e])];
                if (dx < 0) dx = -dx;
                if (dy < 0) dy = -dy;
                m_cost += dx + dy - 1;
                m_c1   += (dx + 1) / 2 + (dy + 1) / 2 - 1;
            end
            m_cyc += 3 * n + 1;
        end
    endtask

    task automatic fill_random(input int n, input int nn);
        for (int e = 0; e < n; e++) begin
            rom_src[e] = 6'($urandom_range(nn - 1, 0));
            rom_dst[e] = 6'($urandom_range(nn - 1, 0));
        end
    endtask

    // One run: start, optional start-while-busy poke, optional reset abort, then result checks.
    task automatic do_run(input string tag, input bit sel, input int gw, input int gh,
                          input logic [31:0] sd, input int n, input int poke_at, input int rst_at);
        int   k;
        logic seen;
        model(gw, gh, sd, n);
        @(negedge clk);
        if (sel) begin b_start = 1'b1; b_seed = sd; b_n = 9'(n); end
        else     begin a_start = 1'b1; a_seed = sd; a_n = 9'(n); end
        k = 0; seen = 1'b0;
        while (!seen && k < 20000) begin
            @(negedge clk);
            k++;
            a_start = 1'b0; b_start = 1'b0;
            if (k == rst_at) begin
                reset = 1'b0;
                @(negedge clk);
                chk({tag, ":rst busy"},   32'(a_busy), 0);
                chk({tag, ":rst done"},   32'(a_done), 0);
                chk({tag, ":rst fail"},   32'(a_fail), 0);
                chk({tag, ":rst rd"},     32'(a_rd), 0);
                chk({tag, ":rst addr"},   32'(a_addr), 0);
                chk({tag, ":rst cost"},   a_cost, 0);
                chk({tag, ":rst c1"},     a_c1, 0);
                chk({tag, ":rst cycles"}, a_cyc, 0);
                reset = 1'b1;
                return;
            end
            if (k == poke_at) begin
                if (sel) begin b_start = 1'b1; b_seed = ~sd; b_n = 9'(n + 1); end
                else     begin a_start = 1'b1; a_seed = ~sd; a_n = 9'(n + 1); end
            end
            seen = sel ? b_done : a_done;
        end
        chk({tag, ":done"},    32'(seen), 1);
        chk({tag, ":latency"}, 32'(k + 1), 32'(m_cyc));
        chk({tag, ":fail"},    32'(sel ? b_fail : a_fail), 32'(m_fail));
        chk({tag, ":cost"},    sel ? b_cost : a_cost, m_cost);
        chk({tag, ":cost1"},   sel ? b_c1 : a_c1, m_c1);
        chk({tag, ":cycles"},  sel ? b_cyc : a_cyc, 32'(m_cyc));
        @(negedge clk);
        chk({tag, ":done_pulse"}, 32'(sel ? b_done : a_done), 0);
        chk({tag, ":idle"},       32'(sel ? b_busy : a_busy), 0);
        chk({tag, ":fail_hold"},  32'(sel ? b_fail : a_fail), 32'(m_fail));
        chk({tag, ":cost_hold"},  sel ? b_cost : a_cost, m_cost);
    endtask

    initial begin
        logic [31:0] sd;
        int n;
        reset = 1'b0;
        a_start = 1'b0; a_seed = '0; a_n = '0;
        b_start = 1'b0; b_seed = '0; b_n = '0;
        for (int e = 0; e < 512; e++) begin rom_src[e] = '0; rom_dst[e] = '0; end
        repeat (3) @(negedge clk);
        chk("reset busy",   32'(a_busy), 0);
        chk("reset done",   32'(a_done), 0);
        chk("reset fail",   32'(a_fail), 0);
        chk("reset rd",     32'(a_rd), 0);
        chk("reset addr",   32'(a_addr), 0);
        chk("reset cost",   a_cost, 0);
        chk("reset c1",     a_c1, 0);
        chk("reset cycles", a_cyc, 0);
        reset = 1'b1;
        @(negedge clk);

        // Empty edge list: accept, CLEAR, DONE.
        do_run("n0", 1'b0, 8, 8, 32'hCAFE_0001, 0, 0, 0);
        chk("n0 cycles", a_cyc, 3);
        chk("n0 cost", a_cost, 0);

        // Single edge 0->1, seed 1.
        rom_src[0] = 6'd0; rom_dst[0] = 6'd1;
        do_run("e01", 1'b0, 8, 8, 32'd1, 1, 0, 0);

        // Self loop: one placement on an empty grid, -1 to both costs, 10-cycle run.
        rom_src[0] = 6'd3; rom_dst[0] = 6'd3;
        do_run("loop", 1'b0, 8, 8, 32'h5EED_1234, 1, 0, 0);
        chk("loop cost",   a_cost, 32'hFFFF_FFFF);
        chk("loop c1",     a_c1, 32'hFFFF_FFFF);
        chk("loop cycles", a_cyc, 10);

        // Seed 0 runs as seed 1.
        fill_random(6, 10);
        do_run("seed0", 1'b0, 8, 8, 32'd0, 6, 0, 0);

        // 71-edge structured graph with the fixed seed.
        for (int e = 0; e < 71; e++) begin
            rom_src[e] = 6'(e % 24);
            rom_dst[e] = 6'((e * 5 + 7) % 24);
        end
        do_run("poly", 1'b0, 8, 8, 32'd998320034, 71, 0, 0);

        // Random graphs and seeds, with a start pulse while busy.
        for (int j = 0; j < 10; j++) begin
            n = int'($urandom_range(30, 1));
            fill_random(n, int'($urandom_range(20, 4)));
            do_run($sformatf("rnd%0d", j), 1'b0, 8, 8, $urandom, n, int'($urandom_range(6, 3)), 0);
        end

        // Reset at cycle 20 of a run, then the same run uninterrupted.
        fill_random(12, 16);
        sd = $urandom;
        do_run("abort", 1'b0, 8, 8, sd, 12, 0, 20);
        do_run("rerun", 1'b0, 8, 8, sd, 12, 0, 0);

        // 2x2 grid: a 5-node star cannot fit.
        for (int e = 0; e < 4; e++) begin rom_src[e] = 6'd0; rom_dst[e] = 6'(e + 1); end
        do_run("star5", 1'b1, 2, 2, 32'h1357_9BDF, 4, 0, 0);
        chk("star5 fail", 32'(b_fail), 1);
        chk("star5 cost", b_cost, 0);

        // 4-node star fits; pick a seed whose walk finds every cell in budget.
        sd = 32'h2468_ACE1;
        for (int j = 0; j < 64; j++) begin
            model(2, 2, sd, 3);
            if (!m_fail) break;
            sd = $urandom;
        end
        do_run("star4", 1'b1, 2, 2, sd, 3, 0, 0);
        chk("star4 fail clear", 32'(b_fail), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
